// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    FETCH = 2'b01,
    DATA  = 2'b10
  } owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic        is32;
    logic [31:0] wdata;
  } mem_req_t;

  localparam int STREAK_W = 8;

endpackage

// File: rtl/arb_priority_pick.sv
// rtl/arb_priority_pick.sv - data-first pick with a bounded streak so fetch cannot starve
module arb_priority_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic                if_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] streak_cnt,
  output owner_e              winner
);

  logic fetch_turn;

  assign fetch_turn = if_req && (MAX_STREAK != 0) &&
                      (streak_cnt == STREAK_W'(MAX_STREAK));

  always_comb begin
    winner = NONE;
    if (d_req && !fetch_turn) begin
      winner = DATA;
    end else if (if_req) begin
      winner = FETCH;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one Ram port between instruction fetch and load/store
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int MAX_STREAK  = 4,
  parameter int ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_is32,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic        mem_is32,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  owner
);

  localparam logic [3:0]          LAT_INIT   = 4'(MEM_LATENCY - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  arb_state_e          state, next_state;
  owner_e              winner, owner_q;
  mem_req_t            req_q;
  logic [3:0]          lat_cnt;
  logic [STREAK_W-1:0] streak_cnt;
  logic                err_q;
  logic                busy_q;
  logic                misaligned;
  logic [31:0]         if_rdata_q, d_rdata_q;

  assign misaligned = (ALIGN_CHECK != 0) && d_is32 && (d_addr[1:0] != 2'b00);

  arb_priority_pick #(
    .MAX_STREAK (MAX_STREAK)
  ) u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .streak_cnt (streak_cnt),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (winner == DATA && misaligned) begin
          next_state = DONE;
        end else if (winner != NONE) begin
          next_state = ACCESS;
        end
      end
      ACCESS: if (lat_cnt == 4'd0) next_state = DONE;
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes decode from the state register so a reset kills mem_we at once.
  always_comb begin
    mem_we  = (state == ACCESS) && req_q.we;
    if_done = (state == DONE) && (owner_q == FETCH);
    d_done  = (state == DONE) && (owner_q == DATA);
    d_err   = d_done && err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= NONE;
      busy_q     <= 1'b0;
      req_q      <= '0;
      lat_cnt    <= 4'd0;
      streak_cnt <= '0;
      err_q      <= 1'b0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      busy_q <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (winner != NONE) begin
            owner_q <= winner;
            lat_cnt <= LAT_INIT;
            if (winner == FETCH) begin
              req_q.addr  <= if_addr;
              req_q.we    <= 1'b0;
              req_q.is32  <= 1'b1;
              req_q.wdata <= 32'd0;
              err_q       <= 1'b0;
              streak_cnt  <= '0;
            end else begin
              req_q.addr  <= d_addr;
              req_q.we    <= d_we && !misaligned;
              req_q.is32  <= d_is32;
              req_q.wdata <= d_wdata;
              err_q       <= misaligned;
              if (!if_req) begin
                streak_cnt <= '0;
              end else if (streak_cnt != STREAK_MAX) begin
                streak_cnt <= streak_cnt + 1'b1;
              end
            end
          end
        end
        ACCESS: begin
          if (lat_cnt == 4'd0) begin
            if (!req_q.we) begin
              if (owner_q == FETCH) begin
                if_rdata_q <= mem_rdata;
              end else begin
                d_rdata_q <= req_q.is32 ? mem_rdata : {24'd0, mem_rdata[7:0]};
              end
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        DONE: owner_q <= NONE;
        default: ;
      endcase
    end
  end

  assign mem_addr  = req_q.addr;
  assign mem_is32  = req_q.is32;
  assign mem_wdata = req_q.wdata;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n, rst3_n;
  logic        if_req, if_req3;
  logic [31:0] if_addr;
  logic        d_req, d_we, d_is32, d_req3;
  logic [31:0] d_addr, d_wdata;
  logic [31:0] mem_rdata;
  logic        if_done, d_done, d_err, mem_we, mem_is32, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0]  owner;
  logic        if_done3, d_done3, d_err3, mem_we3, mem_is32_3, busy3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3;
  logic [1:0]  owner3;

  int checks = 0;
  int failures = 0;

  logic [31:0] if_exp_q[$];
  logic [32:0] d_exp_q[$];
  logic [7:0]  order_log[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(LAT), .MAX_STREAK(4), .ALIGN_CHECK(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_is32(d_is32), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_is32(mem_is32), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .MAX_STREAK(4), .ALIGN_CHECK(1)) u_dut3 (
    .clk(clk), .rst_n(rst3_n),
    .if_req(if_req3), .if_addr(if_addr), .if_done(if_done3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(1'b1), .d_is32(1'b1), .d_addr(32'h0000_0040), .d_wdata(32'h1234_5678),
    .d_done(d_done3), .d_err(d_err3), .d_rdata(d_rdata3),
    .mem_addr(mem_addr3), .mem_we(mem_we3), .mem_is32(mem_is32_3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata), .busy(busy3), .owner(owner3)
  );

  // Byte-addressed Ram model; returns the full little-endian word at mem_addr.
  logic [7:0] bmem [0:511];
  logic [8:0] ma;
  assign ma = mem_addr[8:0];
  assign mem_rdata = {bmem[ma + 9'd3], bmem[ma + 9'd2], bmem[ma + 9'd1], bmem[ma]};

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 512; i++) bmem[i] <= 8'h00;
      bmem[9'h100] <= 8'h93; bmem[9'h101] <= 8'h02; bmem[9'h102] <= 8'hB0; bmem[9'h103] <= 8'h07;
      bmem[9'h104] <= 8'hEF; bmem[9'h105] <= 8'hBE; bmem[9'h106] <= 8'hAD; bmem[9'h107] <= 8'hDE;
      bmem[9'h080] <= 8'h44; bmem[9'h081] <= 8'h33; bmem[9'h082] <= 8'h22; bmem[9'h083] <= 8'h11;
      bmem[9'h07C] <= 8'hAA; bmem[9'h07D] <= 8'hBB; bmem[9'h07E] <= 8'hCC;
    end else if (mem_we) begin
      if (mem_is32) begin
        bmem[ma]         <= mem_wdata[7:0];
        bmem[ma + 9'd1]  <= mem_wdata[15:8];
        bmem[ma + 9'd2]  <= mem_wdata[23:16];
        bmem[ma + 9'd3]  <= mem_wdata[31:24];
      end else begin
        bmem[ma] <= mem_wdata[7:0];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (if_done) begin
        order_log.push_back("F");
        if (if_exp_q.size() == 0) flag("if_done_unexpected");
        else chk("if_rdata", if_rdata, if_exp_q.pop_front());
      end
      if (d_done) begin
        logic [32:0] e;
        order_log.push_back("D");
        if (d_exp_q.size() == 0) flag("d_done_unexpected");
        else begin
          e = d_exp_q.pop_front();
          chk("d_rdata", d_rdata, e[31:0]);
          chk("d_err", {31'd0, d_err}, {31'd0, e[32]});
        end
      end
    end
  end

  task automatic data_access(input logic we, input logic is32, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rdata,
                             input logic exp_err, input int exp_lat, input int exp_we);
    int n = 0;
    int we_n = 0;
    bit seen = 0;
    d_exp_q.push_back({exp_err, exp_rdata});
    d_we = we; d_is32 = is32; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    while (n < 200 && !seen) begin
      @(negedge clk);
      n++;
      if (mem_we) begin
        we_n++;
        chk("mem_is32_during_we", {31'd0, mem_is32}, {31'd0, is32});
      end
      if (d_done) seen = 1;
    end
    if (!seen) flag("d_done_timeout");
    else begin
      if (exp_lat != 0) chk("d_latency", n, exp_lat);
      chk("d_owner_at_done", {30'd0, owner}, 32'h2);
      chk("mem_we_cycles", we_n, exp_we);
    end
    @(posedge clk);
    #1 d_req = 1'b0;
  endtask

  task automatic fetch_access(input logic [31:0] addr, input logic [31:0] exp_data,
                              input int exp_lat);
    int n = 0;
    int we_n = 0;
    bit seen = 0;
    if_exp_q.push_back(exp_data);
    if_addr = addr; if_req = 1'b1;
    while (n < 200 && !seen) begin
      @(negedge clk);
      n++;
      if (mem_we) we_n++;
      if (if_done) seen = 1;
    end
    if (!seen) flag("if_done_timeout");
    else begin
      if (exp_lat != 0) begin
        chk("if_latency", n, exp_lat);
        chk("if_mem_we_cycles", we_n, 0);
      end
      chk("if_owner_at_done", {30'd0, owner}, 32'h1);
      chk("busy_at_done", {31'd0, busy}, 32'h1);
    end
    @(posedge clk);
    #1 if_req = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_ord [6];
    int done3;
    exp_ord = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h46, 8'h44};
    rst_n = 1'b0; rst3_n = 1'b0;
    if_req = 1'b0; if_req3 = 1'b0; d_req = 1'b0; d_req3 = 1'b0;
    if_addr = 32'd0; d_we = 1'b0; d_is32 = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_is32", {31'd0, mem_is32}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_dones", {30'd0, if_done, d_done}, 32'd0);
    rst_n = 1'b1; rst3_n = 1'b1;

    fetch_access(32'h100, 32'h07B0_0293, LAT + 2);

    order_log.delete();
    fork
      data_access(1'b0, 1'b1, 32'h80, 32'd0, 32'h1122_3344, 1'b0, LAT + 2, 0);
      fetch_access(32'h100, 32'h07B0_0293, 2 * LAT + 4);
    join
    chk("simul_order_len", order_log.size(), 2);
    if (order_log.size() == 2) begin
      chk("simul_first", {24'd0, order_log[0]}, 32'h44);
      chk("simul_second", {24'd0, order_log[1]}, 32'h46);
    end

    order_log.delete();
    fork
      begin
        repeat (5) data_access(1'b0, 1'b1, 32'h80, 32'd0, 32'h1122_3344, 1'b0, 0, 0);
      end
      fetch_access(32'h104, 32'hDEAD_BEEF, 0);
    join
    chk("streak_order_len", order_log.size(), 6);
    if (order_log.size() == 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("streak_grant_%0d", i), {24'd0, order_log[i]}, {24'd0, exp_ord[i]});
    end

    data_access(1'b1, 1'b0, 32'h7B, 32'hFFFF_FF58, 32'h1122_3344, 1'b0, LAT + 2, LAT);
    data_access(1'b0, 1'b0, 32'h7B, 32'd0, 32'h0000_0058, 1'b0, LAT + 2, 0);
    data_access(1'b0, 1'b1, 32'h81, 32'd0, 32'h0000_0058, 1'b1, 2, 0);
    data_access(1'b1, 1'b1, 32'h90, 32'hCAFE_F00D, 32'h0000_0058, 1'b0, LAT + 2, LAT);
    data_access(1'b0, 1'b1, 32'h90, 32'd0, 32'hCAFE_F00D, 1'b0, LAT + 2, 0);

    // Reset the MEM_LATENCY=3 instance in the second ACCESS cycle of a write.
    done3 = 0;
    d_req3 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rst_mid_we_before", {31'd0, mem_we3}, 32'd1);
    rst3_n = 1'b0;
    #1;
    chk("rst_mid_we_async", {31'd0, mem_we3}, 32'd0);
    d_req3 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (d_done3 || if_done3) done3++;
    end
    @(posedge clk);
    #1 rst3_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (d_done3 || if_done3) done3++;
    end
    chk("rst_mid_no_done", done3, 0);
    chk("rst_mid_owner", {30'd0, owner3}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy3}, 32'd0);

    chk("if_queue_drained", if_exp_q.size(), 0);
    chk("d_queue_drained", d_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
